// File: rtl/program_sequencer_pkg.sv
// program_sequencer_pkg: shared CPU sequencer definitions (ATC bits, FSM states, reset PC).
// Revision: 1.0
`default_nettype none

package program_sequencer_pkg;

  localparam int ATC_PUSH = 0;
  localparam int ATC_POP  = 1;
  localparam int ATC_ADD  = 2;
  localparam int ATC_MULT = 3;
  localparam int ATC_SUB  = 4;
  localparam int ATC_DIV  = 5;
  localparam int ATC_OFLW = 6;

  localparam int RESET_PC_DEFAULT = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_STEP = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/program_sequencer_atc_latch.sv
// program_sequencer_atc_latch: rising-edge detect and pending flags for attention events.
// Revision: 1.0
`default_nettype none

module program_sequencer_atc_latch #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] events,
  input  logic         consume,
  input  logic [2:0]   consume_sel,
  input  logic         clear_all,
  output logic [N-1:0] pending
);

  logic [N-1:0] hist;
  logic [N-1:0] rise;
  logic [N-1:0] clr_mask;
  logic [N-1:0] pending_next;

  always_comb begin
    rise     = events & ~hist;
    clr_mask = '0;
    if (clear_all) clr_mask = '1;
    if (consume)   clr_mask = clr_mask | (N'(1) << consume_sel);
    // A fresh rise beats any clear on the same bit so no event is lost.
    pending_next = (pending & ~clr_mask) | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist    <= '0;
      pending <= '0;
    end else begin
      hist    <= events;
      pending <= pending_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/program_sequencer.sv
// program_sequencer: program counter, run/step/halt FSM and JMP/ATC redirect resolution.
// Revision: 1.0
`default_nettype none

module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int              ADDR_W   = 8,
  parameter int              ATC_N    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step_mode,
  input  logic              step,
  input  logic              stall,
  input  logic              jmp_req,
  input  logic              jmp_cond,
  input  logic              atc_req,
  input  logic [2:0]        atc_sel,
  input  logic [ADDR_W-1:0] target,
  input  logic [ATC_N-1:0]  atc_event,
  input  logic              atc_clear_all,
  output logic [ADDR_W-1:0] instr_addr,
  output logic [ATC_N-1:0]  atc_pending,
  output logic              redirect,
  output logic [1:0]        state_o
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc_next;
  logic              redirect_next;
  logic              adv;
  logic              jmp_taken;
  logic              atc_taken;

  program_sequencer_atc_latch #(
    .N(ATC_N)
  ) u_atc_latch (
    .clk         (clk),
    .rst_n       (rst_n),
    .events      (atc_event),
    .consume     (adv && atc_taken),
    .consume_sel (atc_sel),
    .clear_all   (atc_clear_all),
    .pending     (atc_pending)
  );

  always_comb begin
    adv       = !stall && ((state == ST_RUN) || ((state == ST_STEP) && step));
    jmp_taken = jmp_req && jmp_cond;
    // JMP owns the cycle when both requests appear together.
    atc_taken = !jmp_req && atc_req && atc_pending[atc_sel];

    pc_next       = instr_addr;
    state_next    = state;
    redirect_next = redirect;

    if (!stall) begin
      redirect_next = 1'b0;
      case (state)
        ST_HALT: begin
          if (|atc_pending) begin
            pc_next    = instr_addr + ADDR_W'(1);
            state_next = step_mode ? ST_STEP : ST_RUN;
          end
        end
        default: begin
          state_next = step_mode ? ST_STEP : ST_RUN;
          if (adv) begin
            if (jmp_taken) begin
              pc_next       = target;
              redirect_next = 1'b1;
              if (target == instr_addr) state_next = ST_HALT;
            end else if (atc_taken) begin
              pc_next       = target;
              redirect_next = 1'b1;
            end else begin
              pc_next = instr_addr + ADDR_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_addr <= RESET_PC;
      redirect   <= 1'b0;
      state      <= ST_RUN;
    end else begin
      instr_addr <= pc_next;
      redirect   <= redirect_next;
      state      <= state_next;
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenarios plus randomized run against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       step_mode, step, stall;
  logic       jmp_req, jmp_cond, atc_req;
  logic [2:0] atc_sel;
  logic [7:0] target;
  logic [7:0] atc_event;
  logic       atc_clear_all;
  logic [7:0] instr_addr;
  logic [7:0] atc_pending;
  logic       redirect;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_errors = 0;
  bit run_cmp  = 1'b0;

  // Reference model state
  logic [7:0] m_pc;
  logic [7:0] m_pend;
  logic [7:0] m_prev_ev;
  logic       m_redir;
  int         m_state;   // 0 run, 1 step, 2 halt

  program_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .step_mode     (step_mode),
    .step          (step),
    .stall         (stall),
    .jmp_req       (jmp_req),
    .jmp_cond      (jmp_cond),
    .atc_req       (atc_req),
    .atc_sel       (atc_sel),
    .target        (target),
    .atc_event     (atc_event),
    .atc_clear_all (atc_clear_all),
    .instr_addr    (instr_addr),
    .atc_pending   (atc_pending),
    .redirect      (redirect),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the sequencer must do this edge, from the rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 8'h00; m_pend = 8'h00; m_prev_ev = 8'h00; m_redir = 1'b0; m_state = 0;
    end else begin
      logic [7:0] new_pend;
      logic       can_go, jt, at;
      check("illegal_jmp_and_atc", {31'd0, jmp_req && atc_req}, 32'd0);
      can_go   = !stall && (m_state == 0 || (m_state == 1 && step));
      jt       = jmp_req && jmp_cond;
      at       = !jmp_req && atc_req && m_pend[atc_sel];
      new_pend = atc_clear_all ? 8'h00 : m_pend;
      if (can_go && at) new_pend[atc_sel] = 1'b0;
      new_pend = new_pend | (atc_event & ~m_prev_ev);
      m_prev_ev = atc_event;
      if (!stall) begin
        if (m_state == 2) begin
          m_redir = 1'b0;
          if (m_pend != 0) begin
            m_pc    = m_pc + 8'd1;
            m_state = step_mode ? 1 : 0;
          end
        end else begin
          int nxt;
          nxt = step_mode ? 1 : 0;
          m_redir = 1'b0;
          if (can_go) begin
            if (jt) begin
              if (target == m_pc) nxt = 2;
              m_pc = target; m_redir = 1'b1;
            end else if (at) begin
              m_pc = target; m_redir = 1'b1;
            end else begin
              m_pc = m_pc + 8'd1;
            end
          end
          m_state = nxt;
        end
      end
      m_pend = new_pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n && run_cmp) begin
      check("model_pc", instr_addr, m_pc);
      check("model_pending", atc_pending, m_pend);
      check("model_redirect", redirect, m_redir);
      check("model_state", state_o, m_state);
    end
  end

  task automatic idle();
    stall = 0; step = 0; jmp_req = 0; jmp_cond = 0; atc_req = 0;
    atc_sel = 0; target = 0; atc_clear_all = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic jmp(input logic [7:0] t);
    idle(); jmp_req = 1; jmp_cond = 1; target = t;
  endtask

  initial begin
    rst_n = 1'b1; step_mode = 0; atc_event = 0;
    idle();
    #1 rst_n = 1'b0;
    #11 rst_n = 1'b1;   // release at t=12, between edges
    check("reset_pc", instr_addr, 8'h00);
    check("reset_pending", atc_pending, 8'h00);
    check("reset_redirect", redirect, 1'b0);
    check("reset_state", state_o, 2'd0);
    run_cmp = 1'b1;
    #1;
    tick();
    check("first_increment", instr_addr, 8'h01);

    // Wrap and unconditional jump
    jmp(8'hFF); tick();
    check("jmp_ff_pc", instr_addr, 8'hFF);
    check("jmp_ff_redirect", redirect, 1'b1);
    idle(); tick();
    check("wrap_pc", instr_addr, 8'h00);
    check("wrap_no_redirect", redirect, 1'b0);
    jmp(8'h07); tick();
    check("jmp07_pc", instr_addr, 8'h07);
    check("jmp07_redirect", redirect, 1'b1);
    idle(); tick();
    check("jmp07_redirect_once", redirect, 1'b0);

    // ATC poll
    atc_event[1] = 1; tick();
    check("atc_latched", atc_pending[1], 1'b1);
    atc_req = 1; atc_sel = 1; target = 8'd25; tick();
    check("atc_taken_pc", instr_addr, 8'd25);
    check("atc_consumed", atc_pending[1], 1'b0);
    tick();
    check("atc_not_taken_pc", instr_addr, 8'd26);
    idle(); atc_event[1] = 0; tick();
    atc_event[1] = 1; tick();
    atc_event[1] = 0; tick();
    check("atc_repeat_pending", atc_pending[1], 1'b1);
    atc_req = 1; atc_sel = 1; target = 8'd40; atc_event[1] = 1; tick();
    check("atc_coincident_pc", instr_addr, 8'd40);
    check("atc_coincident_kept", atc_pending[1], 1'b1);
    idle(); atc_clear_all = 1; tick();
    check("clear_all", atc_pending, 8'h00);

    // Stall during JMP
    jmp(8'h50); stall = 1; atc_event[2] = 1;
    repeat (3) begin
      tick();
      check("stall_pc_held", instr_addr, 8'd41);
      check("stall_no_redirect", redirect, 1'b0);
    end
    check("stall_pending_sets", atc_pending[2], 1'b1);
    stall = 0; tick();
    check("stall_release_pc", instr_addr, 8'h50);
    idle(); tick();
    check("stall_jump_once", instr_addr, 8'h51);

    // Single step
    step_mode = 1; tick();
    check("step_entry_pc", instr_addr, 8'h52);
    check("step_state", state_o, 2'd1);
    repeat (4) tick();
    check("step_idle_pc", instr_addr, 8'h52);
    step = 1; tick(); step = 0; tick();
    step = 1; tick(); step = 0;
    check("step_two_pulses", instr_addr, 8'h54);
    step_mode = 0; tick(); tick();
    check("step_resume_run", instr_addr, 8'h55);

    // Halt on self-loop
    atc_clear_all = 1; tick();
    jmp(8'h06); tick();
    tick();
    check("halt_state", state_o, 2'd2);
    check("halt_pc", instr_addr, 8'h06);
    idle(); tick(); tick();
    check("halt_pc_stable", instr_addr, 8'h06);
    atc_event[0] = 1; tick(); tick();
    check("halt_exit_state", state_o, 2'd0);
    check("halt_exit_pc", instr_addr, 8'h07);

    // Asynchronous reset mid-run
    atc_event[3] = 1;
    jmp(8'h2A); tick();
    idle(); #1 rst_n = 1'b0; #1;
    check("async_reset_pc", instr_addr, 8'h00);
    check("async_reset_pending", atc_pending, 8'h00);
    tick(); tick();
    rst_n = 1'b1; atc_event = 0;
    check("post_reset_fetch0", instr_addr, 8'h00);
    tick();
    check("post_reset_fetch1", instr_addr, 8'h01);

    // Randomized run
    for (int seg = 0; seg < 16; seg++) begin
      step_mode = (seg % 4 == 3);
      for (int c = 0; c < 200; c++) begin
        idle();
        stall    = ($urandom_range(0, 7) == 0);
        step     = step_mode && ($urandom_range(0, 2) == 0);
        jmp_req  = ($urandom_range(0, 7) == 0);
        jmp_cond = $urandom_range(0, 1);
        atc_req  = !jmp_req && ($urandom_range(0, 4) == 0);
        atc_sel  = 3'($urandom_range(0, 7));
        target   = ($urandom_range(0, 15) == 0) ? m_pc : 8'($urandom_range(0, 255));
        atc_clear_all = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 9) == 0) atc_event[$urandom_range(0, 7)] ^= 1'b1;
        tick();
      end
    end

    idle();
    tick();
    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Owns the CPU program counter and drives the 8-bit address into the combinational instruction memory.
- Latches asynchronous attention events (button presses, ALU overflow) into per-bit pending flags.
- Resolves JMP/ATC redirects reported by the decoder and supports run, single-step and stall.
- Sits between the instruction decoder/ALU condition logic and the instruction memory.

Parameters:
- ADDR_W, 8, program counter and jump target width (256 instruction slots)
- ATC_N, 8, number of attention bits; the ATC select field is 3 bits
- RESET_PC, 0, program counter value after reset

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- step_mode  in  1  1 = single-step, 0 = free run
- step  in  1  synchronous one-cycle pulse; advances one instruction in step mode
- stall  in  1  datapath busy (e.g. multi-cycle divide); hold PC
- jmp_req  in  1  current instruction is JMP
- jmp_cond  in  1  JMP condition result from compare logic (UNC always 1)
- atc_req  in  1  current instruction is ATC
- atc_sel  in  3  attention bit tested by the ATC instruction
- target  in  ADDR_W  jump/ATC target field (instruction bits 7:0)
- atc_event  in  ATC_N  synchronised, level attention sources
- atc_clear_all  in  1  synchronous flush of all pending flags
- instr_addr  out  ADDR_W  program counter to instruction memory
- atc_pending  out  ATC_N  latched attention flags (for debug LEDs)
- redirect  out  1  registered, high for one cycle after a taken JMP/ATC
- state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (rst_n low, asynchronous): instr_addr=RESET_PC, atc_pending=0, redirect=0, edge-detect history=0, state=RUN. On release, the first fetch is address RESET_PC.
- Advance condition (adv): state==RUN and stall==0, or state==STEP and step==1 and stall==0.
- Next PC when adv:
  - jmp_req&&jmp_cond -> target.
  - Else atc_req&&atc_pending[atc_sel] -> target.
  - Else instr_addr+1, modulo 2^ADDR_W (255 -> 0).
  - jmp_req and atc_req high together is illegal: treat as JMP; the bench asserts it never occurs.
- Latency: PC updates on the clock edge ending the instruction's cycle. instr_addr is registered and instruction memory is combinational, giving one instruction per advancing cycle.
- redirect: registered 1 in the cycle after a taken branch, otherwise 0.
- Attention latching:
  - hist <= atc_event every cycle. rise = atc_event & ~hist.
  - pending[i] sets on rise[i], whether or not the core is advancing.
  - Repeated presses before consumption leave pending=1; there is no count.
  - A taken ATC (adv high) clears pending[atc_sel].
  - A rise on the same bit in the same cycle wins: the flag stays 1 and the new event is not lost.
  - An ATC that is not taken (flag 0) changes nothing.
  - An ATC presented while stalled or waiting for step does not clear its flag.
  - atc_clear_all clears all flags; a same-cycle rise still sets its bit.
- FSM states: RUN(0), STEP(1), HALT(2).
  - RUN -> STEP when step_mode=1, taking effect next cycle; the instruction in flight this cycle still completes.
  - STEP -> RUN when step_mode=0.
  - RUN/STEP -> HALT when adv, jmp_req&&jmp_cond, and target==instr_addr (self-loop). HALT holds PC and keeps attention latching active.
  - HALT -> RUN on any pending bit set, with PC <= instr_addr+1.
  - HALT -> STEP instead when step_mode=1.
- stall freezes the PC, state and redirect. Pending bits still set.

Decomposition:
- Shared cpu definitions header: ATC bit indices (PUSH, POP, ADD, MULT, SUB, DIV, OFLW), FSM state encodings, RESET_PC default.
- One sub-module, atc_latch: edge detect, pending register and set/clear priority. Top level holds PC, FSM and next-PC mux.

Test Plan:
- Reset mid-run: PC at 0x2A, pulse rst_n low asynchronously between edges -> instr_addr=0 immediately, atc_pending=0. First fetch after release is 0x00, then 0x01.
- Wrap: PC=0xFF, no branch -> next instr_addr=0x00. JMP UNC target 0x07 with jmp_cond=1 -> 0x07 next cycle, redirect=1 for one cycle.
- ATC poll: raise atc_event[1], then atc_req sel=1 target 25 -> PC=25 and pending[1] cleared. Second ATC sel=1 -> PC+1. Rise on bit 1 coincident with consume -> pending[1] stays 1.
- Stall: stall=1 for 3 cycles during JMP -> PC held, no redirect, no flag cleared. Release -> jump taken exactly once.
- Single-step: step_mode=1, 4 idle cycles -> PC constant. Two step pulses -> PC advances by exactly 2. step_mode=0 -> free run resumes.
- Halt: JMP to its own address 0x06 -> state=HALT, PC=0x06 stable. atc_event[0] rise -> RUN, PC=0x07.
